modn_cascade_counter: RTL



---
 rtl/modn_cascade_counter.sv | 91 +++++++++
 1 files changed

// File: rtl/modn_cascade_counter.sv
// Multi-digit modulo-MODULUS up/down counter with load clamping and tc/cin cascading.
// Zero latency: count/wrap/load_err update on the sampling edge; no backpressure (en & cin gate the step).
module modn_cascade_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     cin,
  input  logic                     up,
  input  logic                     load,
  input  logic [DIGITS*WIDTH-1:0]  din,
  output logic [DIGITS*WIDTH-1:0]  count,
  output logic                     tc,
  output logic                     wrap,
  output logic                     load_err
);

  if (DIGITS < 1 || DIGITS > 8 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
    $error("modn_cascade_counter: illegal DIGITS/MODULUS/WIDTH combination");
  end

  localparam logic [WIDTH-1:0] DIG_MAX = WIDTH'(MODULUS - 1);

  logic [DIGITS*WIDTH-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic                    load_err_q, load_err_d;
  logic                    all_max, all_zero, step;

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_max  = all_max  & (count_q[i*WIDTH +: WIDTH] == DIG_MAX);
      all_zero = all_zero & (count_q[i*WIDTH +: WIDTH] == '0);
    end
  end

  assign step = en & cin;
  assign tc   = step & (up ? all_max : all_zero);

  always_comb begin
    logic             carry;
    logic [WIDTH-1:0] dig;
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    carry      = 1'b1;
    dig        = '0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = din[i*WIDTH +: WIDTH];
        if (32'(dig) >= MODULUS) begin
          dig        = DIG_MAX;
          load_err_d = 1'b1;
        end
        count_d[i*WIDTH +: WIDTH] = dig;
      end
    end else if (step) begin
      // carry/borrow ripples while every lower digit sits at its roll-over value
      for (int i = 0; i < DIGITS; i++) begin
        dig = count_q[i*WIDTH +: WIDTH];
        if (carry) begin
          if (up) count_d[i*WIDTH +: WIDTH] = (dig == DIG_MAX) ? '0 : dig + 1'b1;
          else    count_d[i*WIDTH +: WIDTH] = (dig == '0) ? DIG_MAX : dig - 1'b1;
        end
        carry = carry & (up ? (dig == DIG_MAX) : (dig == '0));
      end
      wrap_d = up ? all_max : all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
